// File: rtl/temp_spi_pkg.sv
// Shared types and constants for the three-sensor SPI temperature reader.
package temp_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_GAP      = 3'd4
    } spi_state_e;

    localparam int unsigned NBITS_DEF      = 16;
    localparam int unsigned CLK_DIV_DEF    = 4;
    localparam int unsigned GAP_CYCLES_DEF = 1024;

    // Clock edges from frame acceptance to the data_valid edge, default build.
    localparam int unsigned FRAME_CYCLES = (2 * NBITS_DEF + 1) * CLK_DIV_DEF;

    function automatic int unsigned frame_cycles(input int unsigned clk_div,
                                                 input int unsigned nbits);
        return (2 * nbits + 1) * clk_div;
    endfunction

endpackage

// File: rtl/temp_spi_reader_if.sv
// Sensor pins plus telemetry-side request/result signals of the temperature reader.
interface temp_spi_reader_if
    import temp_spi_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEF
);

    logic             start;
    logic             auto_en;
    logic             temp_sck;
    logic             temp_csn;
    logic             temp1_so;
    logic             temp2_so;
    logic             temp3_so;
    logic [NBITS-1:0] t1_data;
    logic [NBITS-1:0] t2_data;
    logic [NBITS-1:0] t3_data;
    logic             data_valid;
    logic [2:0]       fault;
    logic             busy;

    modport master (
        input  start,
        input  auto_en,
        input  temp1_so,
        input  temp2_so,
        input  temp3_so,
        output temp_sck,
        output temp_csn,
        output t1_data,
        output t2_data,
        output t3_data,
        output data_valid,
        output fault,
        output busy
    );

    modport slave (
        output start,
        output auto_en,
        output temp1_so,
        output temp2_so,
        output temp3_so,
        input  temp_sck,
        input  temp_csn,
        input  t1_data,
        input  t2_data,
        input  t3_data,
        input  data_valid,
        input  fault,
        input  busy
    );

endinterface

// File: rtl/temp_spi_shift_ch.sv
// One sensor channel: MSB-first shift register, word latch and open-line detect.
module temp_spi_shift_ch
    import temp_spi_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_so,
    input  logic             i_shift_en,
    input  logic             i_load,
    output logic [NBITS-1:0] o_data,
    output logic             o_fault
);

    logic [NBITS-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_shift_en) begin
            r_sr <= {r_sr[NBITS-2:0], i_so};
        end
    end

    // A pulled-up, disconnected SO line reads back as all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_fault <= 1'b0;
        end else if (i_load) begin
            o_data  <= r_sr;
            o_fault <= &r_sr;
        end
    end

endmodule

// File: rtl/temp_spi_reader.sv
// SPI master reading three temperature sensors in parallel over a shared SCK/CSN.
module temp_spi_reader
    import temp_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned NBITS      = NBITS_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
    input logic                clk,
    input logic                rst_n,
    temp_spi_reader_if.master  bus
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(NBITS);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("temp_spi_reader: CLK_DIV must be within 2..255");
    end
    if (NBITS < 2) begin : g_bad_nbits
        $error("temp_spi_reader: NBITS must be at least 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("temp_spi_reader: GAP_CYCLES must be at least 1");
    end

    spi_state_e        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [GAP_W-1:0]  r_gap;
    logic              r_sck;
    logic              r_csn;
    logic              r_busy;
    logic              r_valid;

    logic              w_div_done;
    logic              w_last_bit;
    logic              w_gap_done;
    logic              w_shift_en;
    logic              w_load;
    logic [2:0]        w_so;
    logic [NBITS-1:0]  w_data [3];
    logic [2:0]        w_fault;

    assign w_div_done = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit = (r_bit == BIT_W'(NBITS - 1));
    assign w_gap_done = (r_gap == GAP_W'(GAP_CYCLES - 1));

    // Capture coincides with the SCK rising edge; the word latches as CSN rises.
    assign w_shift_en = (r_state == ST_SHIFT_LO) && w_div_done;
    assign w_load     = (r_state == ST_CS_HOLD) && w_div_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_sck   <= 1'b0;
            r_csn   <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_div <= '0;
                    if (bus.start || bus.auto_en) begin
                        r_csn   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_bit   <= '0;
                        r_state <= ST_SHIFT_LO;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= ST_SHIFT_HI;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_div_done) begin
                        r_div <= '0;
                        r_sck <= 1'b0;
                        if (w_last_bit) begin
                            r_state <= ST_CS_HOLD;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_state <= ST_SHIFT_LO;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_CS_HOLD: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_csn   <= 1'b1;
                        r_valid <= 1'b1;
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    // Auto mode keeps busy high so back-to-back frames look seamless.
                    if (w_gap_done) begin
                        r_busy  <= bus.auto_en;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_so = {bus.temp3_so, bus.temp2_so, bus.temp1_so};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        temp_spi_shift_ch #(
            .NBITS (NBITS)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_so       (w_so[g]),
            .i_shift_en (w_shift_en),
            .i_load     (w_load),
            .o_data     (w_data[g]),
            .o_fault    (w_fault[g])
        );
    end

    assign bus.temp_sck   = r_sck;
    assign bus.temp_csn   = r_csn;
    assign bus.busy       = r_busy;
    assign bus.data_valid = r_valid;
    assign bus.t1_data    = w_data[0];
    assign bus.t2_data    = w_data[1];
    assign bus.t3_data    = w_data[2];
    assign bus.fault      = w_fault;

endmodule

// File: tb/tb_temp_spi_reader.sv
// Directed bench for temp_spi_reader: default build plus a CLK_DIV=2, NBITS=12 build.
module tb_temp_spi_reader;
    import temp_spi_pkg::*;

    localparam int unsigned N1 = 16;
    localparam int unsigned D1 = 4;
    localparam int unsigned G1 = 1024;
    localparam int unsigned N2 = 12;
    localparam int unsigned D2 = 2;
    localparam int unsigned G2 = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    temp_spi_reader_if #(.NBITS(N1)) bus1 ();
    temp_spi_reader_if #(.NBITS(N2)) bus2 ();

    temp_spi_reader #(.CLK_DIV(D1), .NBITS(N1), .GAP_CYCLES(G1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    temp_spi_reader #(.CLK_DIV(D2), .NBITS(N2), .GAP_CYCLES(G2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Sensor models: MSB out on CSN fall, next bit after each SCK fall.
    logic [N1-1:0] w1 = '0, w2 = '0, w3 = '0;
    logic [N1-1:0] s1 = '0, s2 = '0, s3 = '0;
    logic          tie1 = 1'b0, tie2 = 1'b0, tie3 = 1'b0;
    logic [N2-1:0] v1 = '0, v2 = '0, v3 = '0;
    logic [N2-1:0] q1 = '0, q2 = '0, q3 = '0;
    logic          tie23 = 1'b0;

    always @(negedge bus1.temp_csn) begin s1 = w1; s2 = w2; s3 = w3; end
    always @(negedge bus1.temp_sck) begin s1 = s1 << 1; s2 = s2 << 1; s3 = s3 << 1; end
    assign bus1.temp1_so = tie1 | s1[N1-1];
    assign bus1.temp2_so = tie2 | s2[N1-1];
    assign bus1.temp3_so = tie3 | s3[N1-1];

    always @(negedge bus2.temp_csn) begin q1 = v1; q2 = v2; q3 = v3; end
    always @(negedge bus2.temp_sck) begin q1 = q1 << 1; q2 = q2 << 1; q3 = q3 << 1; end
    assign bus2.temp1_so = q1[N2-1];
    assign bus2.temp2_so = q2[N2-1];
    assign bus2.temp3_so = tie23 | q3[N2-1];

    // Event log of DUT1 outputs, sampled 1 time unit after each rising edge.
    int   rise_t[$];
    int   vld_t[$];
    int   cfall_t[$];
    int   crise_t[$];
    int   bfall_t[$];
    int   vld2_t[$];
    logic p_sck = 1'b0, p_csn = 1'b1, p_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus1.temp_sck === 1'b1 && !p_sck) rise_t.push_back(cyc);
        if (bus1.temp_csn === 1'b0 && p_csn) cfall_t.push_back(cyc);
        if (bus1.temp_csn === 1'b1 && !p_csn) crise_t.push_back(cyc);
        if (bus1.busy === 1'b0 && p_busy) bfall_t.push_back(cyc);
        if (bus1.data_valid === 1'b1) vld_t.push_back(cyc);
        if (bus2.data_valid === 1'b1) vld2_t.push_back(cyc);
        p_sck  = (bus1.temp_sck === 1'b1);
        p_csn  = (bus1.temp_csn === 1'b1);
        p_busy = (bus1.busy === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse1(output int e0);
        @(negedge clk);
        bus1.start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    task automatic wait_vld(input string tag, input int n, input int budget);
        int k = 0;
        while (vld_t.size() < n && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(vld_t.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (bus1.busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(bus1.busy), 32'd0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int e0, r0, v0, c0, cr0, b0, k;
        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.auto_en = 1'b0;
        bus2.start = 1'b0; bus2.auto_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csn",   32'(bus1.temp_csn), 32'd1);
        check("rst_sck",   32'(bus1.temp_sck), 32'd0);
        check("rst_busy",  32'(bus1.busy), 32'd0);
        check("rst_valid", 32'(bus1.data_valid), 32'd0);
        check("rst_t1",    32'(bus1.t1_data), 32'd0);
        check("rst_fault", 32'(bus1.fault), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single frame with default parameters
        w1 = 16'h1A30; w2 = 16'h0C80; w3 = 16'h7FF8;
        r0 = rise_t.size(); v0 = vld_t.size(); c0 = cfall_t.size(); b0 = bfall_t.size();
        pulse1(e0);
        check("f1_busy_e0", 32'(bus1.busy), 32'd1);
        wait_vld("f1_vld_seen", v0 + 1, 400);
        check("f1_csn_fall", 32'(cfall_t[c0] - e0), 32'd0);
        check("f1_nrise",    32'(rise_t.size() - r0), 32'd16);
        check("f1_rise0",    32'(rise_t[r0] - e0), 32'd4);
        check("f1_rise1",    32'(rise_t[r0 + 1] - e0), 32'd12);
        check("f1_rise15",   32'(rise_t[r0 + 15] - e0), 32'd124);
        check("f1_vld_at",   32'(vld_t[v0] - e0), 32'(FRAME_CYCLES));
        check("f1_t1", 32'(bus1.t1_data), 32'h1A30);
        check("f1_t2", 32'(bus1.t2_data), 32'h0C80);
        check("f1_t3", 32'(bus1.t3_data), 32'h7FF8);
        check("f1_fault", 32'(bus1.fault), 32'd0);
        check("f1_csn_high", 32'(bus1.temp_csn), 32'd1);
        @(negedge clk);
        check("f1_vld_1cyc", 32'(bus1.data_valid), 32'd0);
        wait_idle("f1_idle", 1200);
        check("f1_busy_fall", 32'(bfall_t[b0] - e0), 32'd1156);

        // 4: start while busy is ignored
        v0 = vld_t.size(); c0 = cfall_t.size(); b0 = bfall_t.size();
        pulse1(e0);
        wait_until(e0 + 49);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_vld("f4_vld_seen", v0 + 1, 400);
        wait_idle("f4_idle", 1200);
        repeat (60) @(negedge clk);
        check("f4_nvld",      32'(vld_t.size() - v0), 32'd1);
        check("f4_ncsn",      32'(cfall_t.size() - c0), 32'd1);
        check("f4_busy_fall", 32'(bfall_t[b0] - e0), 32'd1156);

        // 5: reset mid-frame aborts without a strobe
        v0 = vld_t.size();
        pulse1(e0);
        wait_until(e0 + 69);
        rst_n = 1'b0;
        #1;
        check("f5_csn",   32'(bus1.temp_csn), 32'd1);
        check("f5_sck",   32'(bus1.temp_sck), 32'd0);
        check("f5_busy",  32'(bus1.busy), 32'd0);
        check("f5_t1",    32'(bus1.t1_data), 32'd0);
        check("f5_t3",    32'(bus1.t3_data), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("f5_no_vld", 32'(vld_t.size() - v0), 32'd0);
        pulse1(e0);
        wait_vld("f5_vld_seen", v0 + 1, 400);
        check("f5_vld_at", 32'(vld_t[v0] - e0), 32'd132);
        check("f5_t1b", 32'(bus1.t1_data), 32'h1A30);
        check("f5_t2b", 32'(bus1.t2_data), 32'h0C80);
        wait_idle("f5_idle", 1200);

        // 2: open line on sensor 2
        w1 = 16'h0000; w2 = 16'h0000; w3 = 16'h0000; tie2 = 1'b1;
        v0 = vld_t.size();
        pulse1(e0);
        wait_vld("f2_vld_seen", v0 + 1, 400);
        check("f2_t1", 32'(bus1.t1_data), 32'h0000);
        check("f2_t2", 32'(bus1.t2_data), 32'hFFFF);
        check("f2_t3", 32'(bus1.t3_data), 32'h0000);
        check("f2_fault", 32'(bus1.fault), 32'b010);
        wait_idle("f2_idle", 1200);
        tie2 = 1'b0;

        // 3: auto mode, three frames, auto_en dropped during the third
        w1 = 16'hFFFF; w2 = 16'h0001; w3 = 16'h8000;
        v0 = vld_t.size(); c0 = cfall_t.size(); cr0 = crise_t.size(); b0 = bfall_t.size();
        @(negedge clk);
        bus1.auto_en = 1'b1;
        e0 = cyc + 1;
        wait_vld("f3_vld2_seen", v0 + 2, 3000);
        k = 0;
        while (cfall_t.size() < c0 + 3 && k < 2000) begin @(negedge clk); k++; end
        check("f3_third_start", 32'(cfall_t.size() - c0), 32'd3);
        repeat (50) @(negedge clk);
        bus1.auto_en = 1'b0;
        wait_vld("f3_vld3_seen", v0 + 3, 400);
        wait_idle("f3_idle", 1200);
        repeat (300) @(negedge clk);
        check("f3_vld_at",    32'(vld_t[v0] - e0), 32'd132);
        check("f3_period1",   32'(vld_t[v0 + 1] - vld_t[v0]), 32'd1157);
        check("f3_period2",   32'(vld_t[v0 + 2] - vld_t[v0 + 1]), 32'd1157);
        check("f3_nvld",      32'(vld_t.size() - v0), 32'd3);
        check("f3_ncsn",      32'(cfall_t.size() - c0), 32'd3);
        check("f3_csn_gap",   32'(cfall_t[c0 + 1] - crise_t[cr0]), 32'd1025);
        check("f3_nbusyfall", 32'(bfall_t.size() - b0), 32'd1);
        check("f3_busy_fall", 32'(bfall_t[b0] - vld_t[v0 + 2]), 32'd1024);
        check("f3_t1", 32'(bus1.t1_data), 32'hFFFF);
        check("f3_t2", 32'(bus1.t2_data), 32'h0001);
        check("f3_t3", 32'(bus1.t3_data), 32'h8000);
        check("f3_fault", 32'(bus1.fault), 32'b001);

        // 6: CLK_DIV=2, NBITS=12 build
        v1 = 12'hA5C; v2 = 12'h5A3; v3 = 12'h000; tie23 = 1'b1;
        v0 = vld2_t.size();
        @(negedge clk);
        bus2.start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus2.start = 1'b0;
        k = 0;
        while (vld2_t.size() < v0 + 1 && k < 200) begin @(negedge clk); k++; end
        check("f6_vld_seen", 32'(vld2_t.size() - v0), 32'd1);
        check("f6_vld_at", 32'(vld2_t[v0] - e0), 32'(frame_cycles(D2, N2)));
        check("f6_t1", 32'(bus2.t1_data), 32'hA5C);
        check("f6_t2", 32'(bus2.t2_data), 32'h5A3);
        check("f6_t3", 32'(bus2.t3_data), 32'hFFF);
        check("f6_fault", 32'(bus2.fault), 32'b100);
        repeat (20) @(negedge clk);
        check("f6_idle", 32'(bus2.busy), 32'd0);
        tie23 = 1'b0; v3 = 12'hFFE;
        v0 = vld2_t.size();
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        k = 0;
        while (vld2_t.size() < v0 + 1 && k < 200) begin @(negedge clk); k++; end
        check("f6b_vld_seen", 32'(vld2_t.size() - v0), 32'd1);
        check("f6b_t3", 32'(bus2.t3_data), 32'hFFE);
        check("f6b_fault", 32'(bus2.fault), 32'b000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/temp_spi_reader.md
Name: temp_spi_reader

Overview:
- SPI master that reads the three on-board digital temperature sensors over a shared SCK/CSN pair.
- Each sensor has its own SO line: temp1_so, temp2_so, temp3_so.
- Drives temp_sck and temp_csn, and shifts in one word from all three sensors simultaneously.
- Presents the three latched words to telemetry logic with a one-cycle valid strobe, either on request or periodically in auto mode.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; legal range 2..255.
- NBITS, 16: bits per sensor word, received MSB first.
- GAP_CYCLES, 1024: minimum clk cycles with temp_csn high between frames; legal minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-frame request; sampled only in IDLE.
- auto_en  in  1  level; continuous back-to-back frames separated by the gap.
- temp_sck  out  1  SPI clock, CPOL=0, registered.
- temp_csn  out  1  shared chip select, active low, registered.
- temp1_so  in  1  sensor 1 serial data.
- temp2_so  in  1  sensor 2 serial data.
- temp3_so  in  1  sensor 3 serial data.
- t1_data  out  NBITS  last complete word from sensor 1.
- t2_data  out  NBITS  last complete word from sensor 2.
- t3_data  out  NBITS  last complete word from sensor 3.
- data_valid  out  1  one-cycle strobe when t1_data..t3_data update.
- fault  out  3  per-channel open-line flag; bit0 = sensor 1.
- busy  out  1  high from frame acceptance until the end of the gap.

Behaviour:
- Reset (async assert, sync release):
  - temp_csn=1, temp_sck=0.
  - t1_data, t2_data, t3_data = 0; fault=0; data_valid=0; busy=0.
  - FSM returns to IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no data_valid is produced.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, CS_HOLD, GAP.
- IDLE:
  - A frame is accepted at clock edge E0 when start=1 or auto_en=1.
  - At E0: temp_csn->0, busy->1, bit counter=0, half-period counter cleared.
- SHIFT_LO:
  - temp_sck=0 for CLK_DIV cycles.
  - The first low half also serves as CS setup time.
- SHIFT_HI:
  - Entered at the edge that raises temp_sck.
  - At that same edge, all three SO inputs are captured into their shift registers (shift left, LSB in).
  - temp_sck stays high for CLK_DIV cycles.
- Bit k (0..NBITS-1) timing:
  - temp_sck rises at E0+(2k+1)*CLK_DIV.
  - temp_sck falls at E0+(2k+2)*CLK_DIV.
- After the NBITS-th falling edge: enter CS_HOLD, temp_sck=0 for CLK_DIV cycles.
- End of CS_HOLD, at edge E0+(2*NBITS+1)*CLK_DIV:
  - temp_csn->1.
  - t1_data..t3_data load from the shift registers.
  - data_valid=1 for exactly one cycle.
  - fault[i]=1 if channel i word is all ones (open/pulled-up line), else 0.
- GAP:
  - temp_csn held high for GAP_CYCLES cycles, then busy->0 and return to IDLE.
  - If auto_en=1 in the last GAP cycle, the next frame is accepted on the following edge with busy staying high.
- Mode changes and requests during a frame:
  - start while busy is ignored and not queued.
  - auto_en falling mid-frame: the current frame completes normally; no further frames start.
- Outputs hold their previous values between strobes.
- No synchronizers on the SO inputs. The sensors update SO after the SCK falling edge, so SO is stable for at least CLK_DIV-1 cycles before the capture edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package temp_spi_pkg:
  - FSM state enum.
  - Default NBITS.
  - Localparam for frame length (2*NBITS+1)*CLK_DIV, used by the bench.
- Sub-module temp_spi_shift_ch, instantiated three times:
  - NBITS shift register.
  - Capture on shift_en.
  - Parallel load of the output word.
  - All-ones fault detect.
- The top level holds the FSM, divider, bit counter and gap counter.

Test Plan:
1. Single frame, defaults. Sensor models return 16'h1A30, 16'h0C80, 16'h7FF8; pulse start. -> temp_csn low at E0; 16 SCK rises at E0+4, +12, …, +124; data_valid at E0+132; t1..t3 match; fault=3'b000.
2. Open line. temp2_so tied 1, others model 16'h0000. -> t2_data=16'hFFFF, fault=3'b010, t1=t3=0.
3. Auto mode. auto_en=1 for three frames. -> data_valid strobes exactly 132+1024+1 cycles apart; temp_csn high ≥1024 cycles between frames. auto_en cleared mid-third frame -> third frame completes, then busy=0 and no fourth frame.
4. Start while busy. Second start pulse at E0+50. -> ignored: exactly one data_valid; busy falls at E0+132+1024.
5. Reset mid-frame. rst_n low at E0+70 for 3 cycles. -> immediately temp_csn=1, temp_sck=0, data=0, busy=0; no data_valid. Fresh start afterwards yields a correct frame.
6. CLK_DIV=2, NBITS=12 build. Sensor returns 12'hA5C. -> data_valid at E0+50; t1_data=12'hA5C.
